// File: rtl/enemy_spawn_ctrl.sv
// Enemy slot spawn/retire controller: paces spawns into ten slots, scores hits,
// charges lives for enemies reaching the bottom edge, and ramps the flying rate.
module enemy_spawn_ctrl #(
   parameter logic [23:0] SPAWN_INTERVAL = 24'd6250000,
   parameter logic [1:0]  START_LIVES    = 2'd3,
   parameter logic [7:0]  LEVEL_STEP     = 8'd8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [9:0] hit,
   input  logic [9:0] touch_edge,
   output logic [9:0] c_en,
   output logic [9:0] des,
   output logic       move_en,
   output logic [1:0] flying_rate,
   output logic [7:0] score,
   output logic [1:0] lives,
   output logic       game_over
);

   localparam int unsigned NSLOT = 10;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_OVER  = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [9:0]  c_en_q, c_en_d;
   logic [9:0]  des_q, des_d;
   logic        move_en_q, move_en_d;
   logic        game_over_q, game_over_d;
   logic [1:0]  rate_q, rate_d;
   logic [7:0]  score_q, score_d;
   logic [1:0]  lives_q, lives_d;
   logic [23:0] timer_q, timer_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [7:0]  lvl_q, lvl_d;

   // Only slots active on this edge count; a simultaneous hit wins over an edge touch.
   logic [9:0] ev_c, hits_c, touches_c;
   assign ev_c      = c_en_q & (hit | touch_edge);
   assign hits_c    = c_en_q & hit;
   assign touches_c = c_en_q & touch_edge & ~hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         c_en_q      <= '0;
         des_q       <= '0;
         move_en_q   <= 1'b0;
         game_over_q <= 1'b0;
         rate_q      <= '0;
         score_q     <= '0;
         lives_q     <= '0;
         timer_q     <= '0;
         ptr_q       <= '0;
         lvl_q       <= '0;
      end else begin
         state_q     <= state_d;
         c_en_q      <= c_en_d;
         des_q       <= des_d;
         move_en_q   <= move_en_d;
         game_over_q <= game_over_d;
         rate_q      <= rate_d;
         score_q     <= score_d;
         lives_q     <= lives_d;
         timer_q     <= timer_d;
         ptr_q       <= ptr_d;
         lvl_q       <= lvl_d;
      end
   end

   always_comb begin : p_next
      logic [3:0] nh;
      logic [3:0] nt;
      logic [8:0] score_sum;
      logic [8:0] lvl_sum;
      logic [3:0] inc;
      logic [4:0] rate_sum;
      logic [1:0] lives_left;
      logic [4:0] isum;
      logic [3:0] idx;
      logic       found;
      logic [3:0] sel;

      state_d   = state_q;
      c_en_d    = c_en_q;
      des_d     = '0;
      rate_d    = rate_q;
      score_d   = score_q;
      lives_d   = lives_q;
      timer_d   = timer_q;
      ptr_d     = ptr_q;
      lvl_d     = lvl_q;

      nh        = 4'($countones(hits_c));
      nt        = 4'($countones(touches_c));
      score_sum = 9'(score_q) + 9'(nh);
      lvl_sum   = 9'(lvl_q) + 9'(nh);
      inc       = '0;
      // Each full LEVEL_STEP of hits bumps the rate; the remainder carries over.
      for (int k = 0; k < 11; k++) begin
         if (lvl_sum >= 9'(LEVEL_STEP)) begin
            lvl_sum = lvl_sum - 9'(LEVEL_STEP);
            inc     = inc + 4'd1;
         end
      end
      rate_sum   = 5'(rate_q) + 5'(inc);
      lives_left = (4'(lives_q) <= nt) ? 2'd0 : lives_q - 2'(nt);

      // Round-robin search for a free slot from the pointer, on registered enables.
      found = 1'b0;
      sel   = '0;
      for (int k = 0; k < 10; k++) begin
         isum = 5'(ptr_q) + 5'(k);
         if (isum >= 5'(NSLOT)) isum = isum - 5'(NSLOT);
         idx = isum[3:0];
         if (!found && !c_en_q[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end

      case (state_q)
         S_IDLE, S_OVER: begin
            c_en_d = '0;
            if (start) begin
               state_d = S_CLEAR;
               des_d   = '1;
            end
         end
         S_CLEAR: begin
            state_d = S_RUN;
            c_en_d  = '0;
            score_d = '0;
            lives_d = START_LIVES;
            rate_d  = '0;
            timer_d = SPAWN_INTERVAL - 24'd1;
            ptr_d   = '0;
            lvl_d   = '0;
         end
         S_RUN: begin
            c_en_d  = c_en_q & ~ev_c;
            des_d   = ev_c;
            score_d = (score_sum > 9'd255) ? 8'hFF : score_sum[7:0];
            lvl_d   = lvl_sum[7:0];
            rate_d  = (rate_sum > 5'd3) ? 2'd3 : rate_sum[1:0];
            lives_d = lives_left;
            if (lives_left == 2'd0) begin
               state_d = S_OVER;
               c_en_d  = '0;
               des_d   = '1;
            end else if (timer_q == 24'd0) begin
               if (found) begin
                  c_en_d[sel] = 1'b1;
                  ptr_d       = (sel == 4'd9) ? 4'd0 : sel + 4'd1;
                  timer_d     = SPAWN_INTERVAL - 24'd1;
               end
            end else begin
               timer_d = timer_q - 24'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      move_en_d   = (state_d == S_RUN);
      game_over_d = (state_d == S_OVER);
   end

   assign c_en        = c_en_q;
   assign des         = des_q;
   assign move_en     = move_en_q;
   assign game_over   = game_over_q;
   assign flying_rate = rate_q;
   assign score       = score_q;
   assign lives       = lives_q;

endmodule

// File: tb/tb_enemy_spawn_ctrl.sv
// Directed and random stimulus for enemy_spawn_ctrl, compared each cycle with a
// slot-level behavioural model of the game rules.
module tb_enemy_spawn_ctrl;

   localparam logic [23:0] SI = 24'd4;
   localparam logic [1:0]  SL = 2'd3;
   localparam logic [7:0]  LS = 8'd2;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [9:0] hit;
   logic [9:0] touch_edge;
   logic [9:0] c_en;
   logic [9:0] des;
   logic       move_en;
   logic [1:0] flying_rate;
   logic [7:0] score;
   logic [1:0] lives;
   logic       game_over;

   always #5 clk = ~clk;

   enemy_spawn_ctrl #(
      .SPAWN_INTERVAL(SI),
      .START_LIVES   (SL),
      .LEVEL_STEP    (LS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .hit        (hit),
      .touch_edge (touch_edge),
      .c_en       (c_en),
      .des        (des),
      .move_en    (move_en),
      .flying_rate(flying_rate),
      .score      (score),
      .lives      (lives),
      .game_over  (game_over)
   );

   int errors = 0;
   int checks = 0;

   // Game model: 0 idle, 1 clearing, 2 playing, 3 game over.
   int       m_state;
   bit [9:0] m_act;
   bit [9:0] m_des;
   int       m_score, m_lives, m_rate, m_lvl, m_timer, m_ptr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_act = '0; m_des = '0;
      m_score = 0; m_lives = 0; m_rate = 0; m_lvl = 0; m_timer = 0; m_ptr = 0;
   endtask

   task automatic model_edge(input bit s, input bit [9:0] h, input bit [9:0] t);
      bit [9:0] old_act;
      bit [9:0] ev;
      int nh, nt, left, idx;
      m_des = '0;
      case (m_state)
         0, 3: begin
            m_act = '0;
            if (s) begin
               m_state = 1;
               m_des   = '1;
            end
         end
         1: begin
            m_state = 2; m_act = '0;
            m_score = 0; m_lives = int'(SL); m_rate = 0; m_lvl = 0;
            m_timer = int'(SI) - 1; m_ptr = 0;
         end
         default: begin
            old_act = m_act; ev = '0; nh = 0; nt = 0;
            for (int i = 0; i < 10; i++) begin
               if (old_act[i] && (h[i] || t[i])) begin
                  ev[i] = 1'b1;
                  if (h[i]) nh++; else nt++;
               end
            end
            m_act   = old_act & ~ev;
            m_des   = ev;
            m_score = (m_score + nh > 255) ? 255 : m_score + nh;
            m_lvl  += nh;
            while (m_lvl >= int'(LS)) begin
               m_lvl -= int'(LS);
               if (m_rate < 3) m_rate++;
            end
            left = m_lives - nt;
            if (left < 0) left = 0;
            m_lives = left;
            if (left == 0) begin
               m_state = 3; m_act = '0; m_des = '1;
            end else if (m_timer == 0) begin
               for (int k = 0; k < 10; k++) begin
                  idx = (m_ptr + k) % 10;
                  if (!old_act[idx]) begin
                     m_act[idx] = 1'b1;
                     m_ptr      = (idx + 1) % 10;
                     m_timer    = int'(SI) - 1;
                     break;
                  end
               end
            end else begin
               m_timer--;
            end
         end
      endcase
   endtask

   task automatic compare_all();
      check("c_en", 32'(c_en), 32'(m_act));
      check("des", 32'(des), 32'(m_des));
      check("move_en", 32'(move_en), 32'(m_state == 2));
      check("game_over", 32'(game_over), 32'(m_state == 3));
      check("flying_rate", 32'(flying_rate), 32'(m_rate));
      check("score", 32'(score), 32'(m_score));
      check("lives", 32'(lives), 32'(m_lives));
   endtask

   task automatic step(input bit s, input bit [9:0] h, input bit [9:0] t);
      @(negedge clk);
      start = s; hit = h; touch_edge = t;
      @(posedge clk);
      model_edge(s, h, t);
      #1 compare_all();
   endtask

   function automatic bit [9:0] pick(input int n);
      bit [9:0] r = '0;
      int c = 0;
      for (int i = 0; i < 10; i++) begin
         if (m_act[i] && c < n) begin
            r[i] = 1'b1;
            c++;
         end
      end
      return r;
   endfunction

   initial begin
      int budget;
      reset = 1'b1; start = 1'b0; hit = '0; touch_edge = '0;
      model_reset();
      #1 compare_all();
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;

      // Game start: one clearing cycle, then spawns every four cycles.
      step(1'b1, '0, '0);
      check("clear_des", 32'(des), 32'h3FF);
      check("clear_move_en", 32'(move_en), 32'd0);
      step(1'b0, '0, '0);
      check("run_move_en", 32'(move_en), 32'd1);
      check("run_lives", 32'(lives), 32'd3);
      repeat (3) step(1'b0, '0, '0);
      check("c_en_before_spawn", 32'(c_en), 32'h000);
      step(1'b0, '0, '0);
      check("c_en_first_spawn", 32'(c_en), 32'h001);
      repeat (4) step(1'b0, '0, '0);
      check("c_en_second_spawn", 32'(c_en), 32'h003);

      // Held hit on slot 0 counts once.
      step(1'b0, 10'h001, '0);
      check("hit0_des", 32'(des), 32'h001);
      check("hit0_score", 32'(score), 32'd1);
      step(1'b0, 10'h001, '0);
      check("hit0_des_once", 32'(des), 32'h000);
      step(1'b0, 10'h001, '0);
      check("hit0_score_once", 32'(score), 32'd1);
      check("hit0_c_en", 32'(c_en[0]), 32'd0);

      // Hit and edge touch together score without costing a life.
      step(1'b0, 10'h002, 10'h002);
      check("hit_touch_score", 32'(score), 32'd2);
      check("hit_touch_lives", 32'(lives), 32'd3);
      check("rate_after_two", 32'(flying_rate), 32'd1);
      for (int n = 0; n < 2; n++) begin
         budget = 0;
         while (m_act == 0 && budget < 50) begin
            step(1'b0, '0, '0);
            budget++;
         end
         check("hit_slot_available", 32'(m_act != 0), 32'd1);
         step(1'b0, pick(1), '0);
      end
      check("rate_after_four", 32'(flying_rate), 32'd2);
      check("score_after_four", 32'(score), 32'd4);

      // Three edge touches at once end the game.
      budget = 0;
      while ($countones(m_act) < 3 && budget < 100) begin
         step(1'b0, '0, '0);
         budget++;
      end
      check("three_active", 32'($countones(m_act) >= 3), 32'd1);
      step(1'b0, '0, pick(3));
      check("over_lives", 32'(lives), 32'd0);
      check("over_flag", 32'(game_over), 32'd1);
      check("over_c_en", 32'(c_en), 32'h000);
      check("over_des", 32'(des), 32'h3FF);
      check("over_move_en", 32'(move_en), 32'd0);
      step(1'b0, '0, '0);
      check("over_des_done", 32'(des), 32'h000);

      // Fill all slots; a freed slot respawns on the following cycle.
      step(1'b1, '0, '0);
      step(1'b0, '0, '0);
      budget = 0;
      while (m_act != 10'h3FF && budget < 200) begin
         step(1'b0, '0, '0);
         budget++;
      end
      check("all_active", 32'(c_en), 32'h3FF);
      repeat (3) step(1'b0, '0, '0);
      check("full_hold", 32'(c_en), 32'h3FF);
      step(1'b0, 10'h020, '0);
      check("slot5_cleared", 32'(c_en), 32'h3DF);
      check("slot5_des", 32'(des), 32'h020);
      step(1'b0, '0, '0);
      check("slot5_respawn", 32'(c_en), 32'h3FF);

      // Reset mid-game acts immediately and leaves the block idle.
      @(negedge clk) reset = 1'b1;
      model_reset();
      @(negedge clk) reset = 1'b0;
      step(1'b1, '0, '0);
      step(1'b0, '0, '0);
      budget = 0;
      while (m_act != 10'h00F && budget < 100) begin
         step(1'b0, '0, '0);
         budget++;
      end
      check("four_active", 32'(c_en), 32'h00F);
      @(negedge clk) reset = 1'b1;
      #1;
      check("rst_c_en", 32'(c_en), 32'h000);
      check("rst_move_en", 32'(move_en), 32'd0);
      check("rst_des", 32'(des), 32'h000);
      check("rst_score", 32'(score), 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 check("rst_held_des", 32'(des), 32'h000);
      @(negedge clk) reset = 1'b0;
      repeat (5) step(1'b0, '0, '0);
      check("idle_hold", 32'(move_en), 32'd0);

      // Random play against the model.
      for (int c = 0; c < 1500; c++) begin
         step($urandom_range(0, 7) == 0,
              10'($urandom & $urandom & $urandom),
              10'($urandom & $urandom & $urandom & $urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/enemy_spawn_ctrl.md
ENEMY_SPAWN_CTRL -- requirements
Module: enemy_spawn_ctrl

Interface
REQ-001: Parameter SPAWN_INTERVAL, 24'd6250000, clk cycles between spawn attempts (min 1).
REQ-002: Parameter START_LIVES, 2'd3, lives loaded at game start (1-3).
REQ-003: Parameter LEVEL_STEP, 8'd8, hits per flying_rate increment (min 1).
REQ-004: Clocking: one clock; reset is asynchronous and active-high; ports named clk and reset.
REQ-005: clk  input  1  system clock, all state on rising edge.
REQ-006: reset  input  1  asynchronous active-high reset.
REQ-007: start  input  1  level-sensitive; begins a game from IDLE or OVER.
REQ-008: hit  input  10  per-slot collision flag from bullet logic.
REQ-009: touch_edge  input  10  per-slot bottom-edge flag from the y-coordinate counters.
REQ-010: c_en  output  10  per-slot active enable to the y-coordinate counters.
REQ-011: des  output  10  per-slot one-cycle clear pulse to the y-coordinate counters.
REQ-012: move_en  output  1  enables the shared move-rate counter.
REQ-013: flying_rate  output  2  move speed select, 0 = slowest tier.
REQ-014: score  output  8  hit count, saturating.
REQ-015: lives  output  2  remaining lives.
REQ-016: game_over  output  1  high while in OVER.

Function
REQ-017: FSM states IDLE, CLEAR, RUN, OVER, all registered.
REQ-018: IDLE/OVER + start=1 -> CLEAR; CLEAR -> RUN unconditionally after exactly one cycle; RUN -> OVER on the edge lives becomes 0.
REQ-019: In CLEAR: des=10'h3FF, c_en=0, score<=0, lives<=START_LIVES, flying_rate<=0, spawn timer<=SPAWN_INTERVAL-1, slot pointer<=0.
REQ-020: In OVER and IDLE: c_en=0, move_en=0, des=0; score, lives and flying_rate hold.
REQ-021: move_en is 1 exactly while state is RUN, registered.
REQ-022: Spawn timer in RUN decrements by 1 per cycle; at 0 it attempts a spawn.
REQ-023: Spawn selection: first slot i with c_en[i]=0 searching pointer, pointer+1, ... mod 10, using registered c_en only.
REQ-024: On successful spawn: c_en[i]<=1, pointer<=(i+1) mod 10, timer<=SPAWN_INTERVAL-1.
REQ-025: If all 10 slots active at timer 0, timer holds at 0 and spawn retries every cycle.
REQ-026: A slot event is counted only when c_en[i]=1 on that edge; hit/touch_edge with c_en[i]=0 are ignored.
REQ-027: On a counted event for slot i: c_en[i]<=0 and des[i]<=1 for exactly one cycle.
REQ-028: hit[i] and touch_edge[i] together: treat as hit only, no life loss.
REQ-029: Counted hits: score<=min(score+popcount(hits),255).
REQ-030: Counted edge touches: lives<=max(lives-popcount(touches),0).
REQ-031: Internal hit-since-level counter; each time it reaches LEVEL_STEP it clears (carrying remainder) and flying_rate increments, saturating at 3.
REQ-032: A slot cleared by an event is not eligible for spawn on the same edge; spawn of slot i and event on slot j!=i in the same cycle are both applied.
REQ-033: On the RUN->OVER edge c_en<=0 and des<=10'h3FF for one cycle; events in that cycle still update score.
REQ-034: Timer width 24 bits; score 8; lives 2; no wrap except pointer mod 10.

Reset
REQ-035: reset=1 asynchronously forces state=IDLE, c_en=0, des=0, move_en=0, flying_rate=0, score=0, lives=0, game_over=0, timer=0, pointer=0, level counter=0.
REQ-036: reset asserted mid-RUN takes effect immediately, no des pulse generated; on release block waits in IDLE for start.

Verification (bench uses SPAWN_INTERVAL=4, LEVEL_STEP=2, START_LIVES=3)
REQ-037: reset, then start=1 one cycle -> des=3FF for 1 cycle, then RUN, move_en=1, lives=3; c_en=001 4 cycles after RUN entry, 003 after 8.
REQ-038: slot0 active, hit[0]=1 held 3 cycles -> des[0] single 1-cycle pulse, score=1 (not 3), c_en[0]=0.
REQ-039: hit[1]&touch_edge[1] same cycle -> score+1, lives unchanged; two further hits -> flying_rate=1 after score reaches 2.
REQ-040: touch_edge on 3 active slots same cycle with lives=3 -> lives=0, game_over=1, c_en=0, des=3FF one cycle, move_en=0.
REQ-041: all 10 slots active -> timer holds 0; hit[5] -> next cycle after clear, slot 5 spawns (pointer wraps), c_en=3FF.
REQ-042: reset asserted mid-RUN with c_en=00F -> same-cycle c_en=0, move_en=0, state IDLE, no des pulse.
